// File: rtl/multdiv_scheduler_if.sv
// multdiv_scheduler_if
//   Bundles the X-stage issue, multdiv datapath, stall-controller and
//   register-file write-port signals of the multdiv scheduler.
//   slave  : the scheduler itself (consumes issue/datapath/W-stage inputs,
//            drives start pulses, operands, stall info and the merged write).
//   master : whatever surrounds the scheduler (pipeline, datapath, RF).
interface multdiv_scheduler_if;
  // X-stage issue
  logic [31:0] issue_insn;
  logic        issue_valid;
  logic [31:0] op_a;
  logic [31:0] op_b;
  // multdiv datapath
  logic        md_start_mult;
  logic        md_start_div;
  logic [31:0] md_opA;
  logic [31:0] md_opB;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_ready;
  // stall controller
  logic        multOngoing;
  logic [31:0] inM;
  // W-stage write request and merged register-file write port
  logic        wb_pipe_we;
  logic [4:0]  wb_pipe_rd;
  logic [31:0] wb_pipe_data;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;

  modport slave (
    input  issue_insn, issue_valid, op_a, op_b,
    input  md_result, md_exception, md_ready,
    input  wb_pipe_we, wb_pipe_rd, wb_pipe_data,
    output md_start_mult, md_start_div, md_opA, md_opB,
    output multOngoing, inM,
    output rf_we, rf_rd, rf_data
  );

  modport master (
    output issue_insn, issue_valid, op_a, op_b,
    output md_result, md_exception, md_ready,
    output wb_pipe_we, wb_pipe_rd, wb_pipe_data,
    input  md_start_mult, md_start_div, md_opA, md_opB,
    input  multOngoing, inM,
    input  rf_we, rf_rd, rf_data
  );
endinterface

// File: rtl/multdiv_scheduler.sv
// multdiv_scheduler
//   Issue/writeback sequencer for the shared multi-cycle multiply/divide
//   unit. Captures a mult/div leaving X, pulses the datapath start, holds
//   multOngoing/inM for the stall controller until the result retires, and
//   merges the late multdiv result onto the single register-file write port
//   (the W-stage pipeline write always wins). Exceptions and timeouts become
//   an $r30 rstatus write.
// Ports:
//   clock  : sole clock, rising edge
//   reset  : synchronous, active-high
//   bus    : multdiv_scheduler_if.slave (issue, datapath, stall, RF port)
module multdiv_scheduler #(
  parameter int TIMEOUT     = 64,
  parameter int RSTATUS_MUL = 4,
  parameter int RSTATUS_DIV = 5
) (
  input logic                 clock,
  input logic                 reset,
  multdiv_scheduler_if.slave  bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, WB_PEND} state_t;

  state_t      state_q, state_d;
  logic        first_q, first_d;     // marks the start-pulse BUSY cycle
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] inm_q, inm_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [4:0]  rd_q, rd_d;
  logic        div_q, div_d;
  logic [4:0]  buf_rd_q, buf_rd_d;
  logic [31:0] buf_data_q, buf_data_d;

  logic        dec_mult, dec_div, is_md;
  logic [31:0] rstatus_val;
  logic        buf_fire;

  assign dec_mult    = (bus.issue_insn[31:27] == 5'b00000) && (bus.issue_insn[6:2] == 5'b00110);
  assign dec_div     = (bus.issue_insn[31:27] == 5'b00000) && (bus.issue_insn[6:2] == 5'b00111);
  assign is_md       = bus.issue_valid && (dec_mult || dec_div);
  assign rstatus_val = div_q ? 32'(RSTATUS_DIV) : 32'(RSTATUS_MUL);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      first_q    <= 1'b0;
      cnt_q      <= '0;
      inm_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      rd_q       <= '0;
      div_q      <= 1'b0;
      buf_rd_q   <= '0;
      buf_data_q <= '0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      cnt_q      <= cnt_d;
      inm_q      <= inm_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      rd_q       <= rd_d;
      div_q      <= div_d;
      buf_rd_q   <= buf_rd_d;
      buf_data_q <= buf_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    first_d    = 1'b0;
    cnt_d      = cnt_q;
    inm_d      = inm_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    rd_d       = rd_q;
    div_d      = div_q;
    buf_rd_d   = buf_rd_q;
    buf_data_d = buf_data_q;
    unique case (state_q)
      IDLE: begin
        if (is_md) begin
          inm_d   = bus.issue_insn;
          opa_d   = bus.op_a;
          opb_d   = bus.op_b;
          rd_d    = bus.issue_insn[26:22];
          div_d   = dec_div;
          cnt_d   = '0;
          first_d = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        if (bus.md_ready) begin
          if (bus.md_exception) begin
            buf_rd_d   = 5'd30;
            buf_data_d = rstatus_val;
            state_d    = WB_PEND;
          end else if (rd_q != 5'd0) begin
            buf_rd_d   = rd_q;
            buf_data_d = bus.md_result;
            state_d    = WB_PEND;
          end else begin
            state_d    = IDLE;
          end
        end else if (cnt_q >= CNT_LAST) begin
          // This BUSY cycle brings the count to TIMEOUT: give up.
          buf_rd_d   = 5'd30;
          buf_data_d = rstatus_val;
          state_d    = WB_PEND;
        end
      end
      WB_PEND: begin
        if (!bus.wb_pipe_we) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs. Reset gates the state-derived outputs so an aborted
  // operation emits neither a start pulse nor a buffered write.
  always_comb begin
    buf_fire          = !reset && (state_q == WB_PEND) && !bus.wb_pipe_we;
    bus.md_start_mult = !reset && (state_q == BUSY) && first_q && !div_q;
    bus.md_start_div  = !reset && (state_q == BUSY) && first_q && div_q;
    bus.md_opA        = opa_q;
    bus.md_opB        = opb_q;
    bus.multOngoing   = 1'b0;
    bus.inM           = '0;
    if (!reset) begin
      if (state_q != IDLE) begin
        bus.multOngoing = 1'b1;
        bus.inM         = inm_q;
      end else if (is_md) begin
        // Issue-cycle term lets a dependent instruction in D stall now.
        bus.multOngoing = 1'b1;
        bus.inM         = bus.issue_insn;
      end
    end
    bus.rf_we   = bus.wb_pipe_we || buf_fire;
    bus.rf_rd   = buf_fire ? buf_rd_q : bus.wb_pipe_rd;
    bus.rf_data = buf_fire ? buf_data_q : bus.wb_pipe_data;
  end
endmodule

// File: tb/tb_multdiv_scheduler.sv
module tb_multdiv_scheduler;
  localparam int TIMEOUT = 64;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clock = ~clock;

  multdiv_scheduler_if bus();

  multdiv_scheduler #(.TIMEOUT(TIMEOUT), .RSTATUS_MUL(4), .RSTATUS_DIV(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input int cyc, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] md_insn(input bit div, input logic [4:0] rd);
    logic [14:0] mid;
    logic [1:0]  lo;
    mid = 15'($urandom);
    lo  = 2'($urandom);
    return {5'b00000, rd, mid, (div ? 5'b00111 : 5'b00110), lo};
  endfunction

  task automatic idle_inputs();
    bus.issue_valid  = 1'b0;
    bus.issue_insn   = $urandom;
    bus.op_a         = $urandom;
    bus.op_b         = $urandom;
    bus.md_ready     = 1'b0;
    bus.md_exception = 1'b0;
    bus.md_result    = $urandom;
    bus.wb_pipe_we   = 1'b0;
    bus.wb_pipe_rd   = 5'($urandom);
    bus.wb_pipe_data = $urandom;
  endtask

  // Checks the write port against "pipeline passes through, buffered write
  // only when fire", with the expected buffered rd/data.
  task automatic check_port(input int c, input bit fire, input logic [4:0] erd, input logic [31:0] edata);
    check("rf_we", c, bus.rf_we, bus.wb_pipe_we | fire);
    check("rf_rd", c, bus.rf_rd, fire ? erd : bus.wb_pipe_rd);
    check("rf_data", c, bus.rf_data, fire ? edata : bus.wb_pipe_data);
  endtask

  // One mult/div transaction issued at relative cycle 0. The expected
  // timeline follows from the timing rules: start at 1, result at k (or
  // timeout after TIMEOUT busy cycles), write at k+1+stalls, idle after.
  task automatic run_md(input bit div, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input int k, input bit exc, input bit tmo,
                        input int stalls, input bit illegal);
    logic [31:0] insn;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    int k_eff, wc, last_on;
    bit wr, on, fire;
    insn     = md_insn(div, rd);
    k_eff    = tmo ? TIMEOUT : k;
    wr       = exc || tmo || (rd != 5'd0);
    wc       = wr ? k_eff + 1 + stalls : -1;
    last_on  = wr ? wc : k_eff;
    exp_rd   = (exc || tmo) ? 5'd30 : rd;
    exp_data = (exc || tmo) ? (div ? 32'd5 : 32'd4) : res;
    for (int c = 0; c <= last_on + 1; c++) begin
      @(posedge clock); #1;
      idle_inputs();
      if (c == 0) begin
        bus.issue_valid = 1'b1;
        bus.issue_insn  = insn;
        bus.op_a        = a;
        bus.op_b        = b;
      end
      if (illegal && c == 2) begin
        bus.issue_valid = 1'b1;
        bus.issue_insn  = md_insn(!div, rd + 5'd1);
      end
      if (!tmo && c == k) begin
        bus.md_ready     = 1'b1;
        bus.md_exception = exc;
        bus.md_result    = res;
      end else if (c > k_eff && $urandom_range(0, 3) == 0) begin
        bus.md_ready     = 1'b1;
        bus.md_exception = 1'($urandom);
      end
      if (wr && c > k_eff && c < wc) bus.wb_pipe_we = 1'b1;
      else if (c <= k_eff)           bus.wb_pipe_we = 1'($urandom);
      @(negedge clock);
      on   = (c <= last_on);
      fire = wr && (c == wc);
      check("multOngoing", c, bus.multOngoing, on);
      check("inM", c, bus.inM, on ? insn : 32'd0);
      check("start_mult", c, bus.md_start_mult, (c == 1) && !div);
      check("start_div", c, bus.md_start_div, (c == 1) && div);
      if (c == 1 || c == last_on) begin
        check("md_opA", c, bus.md_opA, a);
        check("md_opB", c, bus.md_opB, b);
      end
      check_port(c, fire, exp_rd, exp_data);
    end
    $display("txn %s rd=%0d k=%0d exc=%0d tmo=%0d stalls=%0d illegal=%0d -> %s",
             div ? "div" : "mult", rd, k_eff, exc, tmo, stalls, illegal,
             wr ? "write" : "discard");
  endtask

  // Reset asserted for one cycle at rc (1 = start cycle) aborts the op.
  task automatic run_reset_mid(input int rc);
    logic [31:0] insn;
    insn = md_insn(1'b0, 5'd7);
    for (int c = 0; c <= rc + 3; c++) begin
      @(posedge clock); #1;
      idle_inputs();
      reset = (c == rc);
      if (c == 0) begin
        bus.issue_valid = 1'b1;
        bus.issue_insn  = insn;
      end
      if (c == rc + 1) begin
        bus.md_ready  = 1'b1;
        bus.md_result = 32'd99;
      end
      @(negedge clock);
      check("rst_start", c, bus.md_start_mult, (c == 1) && (rc > 1));
      if (c != rc) check("rst_ongoing", c, bus.multOngoing, c < rc);
      if (c > rc) begin
        check("rst_inM", c, bus.inM, 32'd0);
        check("rst_opA", c, bus.md_opA, 32'd0);
      end
      check_port(c, 1'b0, 5'd0, 32'd0);
    end
    reset = 1'b0;
    $display("txn reset at cycle %0d aborts mult", rc);
  endtask

  // An instruction that must not be treated as multdiv.
  task automatic run_non_md(input logic [31:0] insn, input bit valid, input string name);
    for (int c = 0; c <= 1; c++) begin
      @(posedge clock); #1;
      idle_inputs();
      if (c == 0) begin
        bus.issue_valid = valid;
        bus.issue_insn  = insn;
      end
      @(negedge clock);
      check("nonmd_ongoing", c, bus.multOngoing, 32'd0);
      check("nonmd_inM", c, bus.inM, 32'd0);
      check("nonmd_start", c, {bus.md_start_mult, bus.md_start_div}, 32'd0);
      check_port(c, 1'b0, 5'd0, 32'd0);
    end
    $display("txn %s ignored", name);
  endtask

  initial begin
    logic [31:0] ins;
    reset = 1'b1;
    idle_inputs();
    bus.wb_pipe_we = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_ongoing", 0, bus.multOngoing, 32'd0);
    check("rst_inM", 0, bus.inM, 32'd0);
    check("rst_start", 0, {bus.md_start_mult, bus.md_start_div}, 32'd0);
    check("rst_opA", 0, bus.md_opA, 32'd0);
    check("rst_opB", 0, bus.md_opB, 32'd0);
    check_port(0, 1'b0, 5'd0, 32'd0);
    $display("txn reset state");
    @(posedge clock); #1;
    reset = 1'b0;
    idle_inputs();

    run_md(1'b0, 5'd5, 32'd6, 32'd7, 32'd42, 4, 1'b0, 1'b0, 0, 1'b0);   // basic mult
    run_md(1'b0, 5'd5, 32'd6, 32'd7, 32'd42, 4, 1'b0, 1'b0, 2, 1'b0);   // port conflict
    run_md(1'b1, 5'd8, 32'd3, 32'd0, 32'd0, 6, 1'b1, 1'b0, 0, 1'b0);    // div by zero
    run_md(1'b0, 5'd9, 32'd1, 32'd2, 32'd2, 0, 1'b0, 1'b1, 1, 1'b0);    // timeout
    run_md(1'b1, 5'd9, 32'd1, 32'd2, 32'd2, 0, 1'b0, 1'b1, 0, 1'b0);    // div timeout
    run_md(1'b0, 5'd0, 32'd2, 32'd3, 32'd6, 3, 1'b0, 1'b0, 0, 1'b0);    // rd=0 discard
    run_md(1'b0, 5'd0, 32'd2, 32'd3, 32'd6, 1, 1'b1, 1'b0, 0, 1'b0);    // rd=0 exception
    run_md(1'b1, 5'd12, 32'd20, 32'd4, 32'd5, 5, 1'b0, 1'b0, 1, 1'b1);  // illegal issue
    run_md(1'b0, 5'd31, 32'd1, 32'd1, 32'd1, 1, 1'b0, 1'b0, 0, 1'b0);   // ready on start cycle
    run_reset_mid(1);
    run_reset_mid(3);
    run_non_md({5'b00000, 5'd4, 15'd0, 5'b00000, 2'b00}, 1'b1, "add");
    run_non_md(md_insn(1'b0, 5'd4), 1'b0, "bubbled mult");
    ins = md_insn(1'b1, 5'd4);
    ins[31:27] = 5'b00101;
    run_non_md(ins, 1'b1, "non-zero opcode");

    for (int i = 0; i < 40; i++) begin
      int k;
      bit exc, ill;
      k   = $urandom_range(1, 10);
      exc = ($urandom_range(0, 7) == 0);
      ill = (k >= 2) && ($urandom_range(0, 3) == 0);
      run_md(1'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
             k, exc, 1'b0, $urandom_range(0, 3), ill);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/multdiv_scheduler.md
# multdiv_scheduler

Issue/writeback sequencer for the shared multi-cycle multiply/divide unit. Captures a `mult`/`div` leaving the X stage, starts the multdiv datapath, and holds `multOngoing`/`inM` for the stall controller until the result retires. Arbitrates the single register-file write port between the normal W-stage write and the late multdiv result; the pipeline always has priority. Converts multdiv exceptions and timeouts into an `$r30` rstatus write.

## Interface
- `TIMEOUT`, default 64: BUSY cycles without `md_ready` before forced exception; counter width is clog2(TIMEOUT+1).
- `RSTATUS_MUL`, default 4: value written to `$r30` on mult exception/timeout.
- `RSTATUS_DIV`, default 5: value written to `$r30` on div exception/timeout.

Ports:
- `clock`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `issue_insn`  in  32  X-stage instruction.
- `issue_valid`  in  1  X-stage instruction is real (not flushed or bubbled).
- `op_a`, `op_b`  in  32  X-stage bypassed operands (rs, rt).
- `md_start_mult`, `md_start_div`  out  1  one-cycle start pulses to the datapath.
- `md_opA`, `md_opB`  out  32  latched operands.
- `md_result`  in  32  datapath result.
- `md_exception`  in  1  overflow or divide-by-zero; qualified by `md_ready`.
- `md_ready`  in  1  result valid.
- `multOngoing`  out  1  to the stall controller.
- `inM`  out  32  in-flight multdiv instruction, to the stall controller.
- `wb_pipe_we`  in  1  W-stage write request.
- `wb_pipe_rd`  in  5  W-stage destination register.
- `wb_pipe_data`  in  32  W-stage write data.
- `rf_we`  out  1  merged register-file write enable.
- `rf_rd`  out  5  merged register-file write address.
- `rf_data`  out  32  merged register-file write data.

## Operation
- Decode `mult`: opcode [31:27]=00000, ALU op [6:2]=00110. Decode `div`: opcode 00000, ALU op 00111. rd=[26:22].
- `is_md` = `issue_valid` AND decoded as `mult` or `div`.
- IDLE:
  - If `is_md`: latch `issue_insn` → inM_r, `op_a`/`op_b` → md_opA/md_opB, rd, and kind (mul/div). Clear the counter. Go to BUSY.
- BUSY:
  - The first BUSY cycle asserts exactly one of `md_start_mult`/`md_start_div`.
  - The counter increments each BUSY cycle and saturates at TIMEOUT.
  - Any BUSY cycle, including the start cycle, with `md_ready`=1:
    - If `md_exception`: buffer rd=30, data=RSTATUS_MUL or RSTATUS_DIV per kind.
    - Else if rd≠0: buffer rd and `md_result`.
    - Else (rd=0): discard the result and go to IDLE.
    - In the first two cases, go to WB_PEND.
  - Counter reaches TIMEOUT with no `md_ready`: buffer as for an exception, go to WB_PEND.
- WB_PEND:
  - If `wb_pipe_we`=0: drive `rf_we`=1 with the buffered rd/data, go to IDLE.
  - Else: pass the pipeline write through and stay.
- Write-port mux: the pipeline write passes through unmodified in every cycle. The buffered write is driven only in a WB_PEND cycle with `wb_pipe_we`=0. A same-rd pipeline write is not special-cased.
- `multOngoing` = (state≠IDLE) OR (IDLE AND `is_md`). The combinational issue-cycle term covers a dependent instruction in D.
- `inM` = `issue_insn` when IDLE AND `is_md`; else inM_r while not IDLE; else 0.
- `is_md` seen while not IDLE is a protocol violation:
  - It is ignored. In-flight state, inM_r, and operands are unchanged.
  - The stall controller prevents it.
- `md_ready` while IDLE or WB_PEND: ignored.

## Timing
- Reset values:
  - State IDLE, counter 0, inM_r 0, buffers 0.
  - All outputs 0, except `rf_*`, which pass the pipeline write through.
- Reset mid-operation aborts it: no start pulse, no `rf_we` from the buffer. The next cycle is IDLE.
- Issue at cycle t:
  - Start pulse at t+1.
  - `md_ready` at t+k (k≥1) → buffered write at t+k+1 if the port is free.
  - `multOngoing` is high t through t+k+1 and low at t+k+2.
- Each cycle of `wb_pipe_we`=1 in WB_PEND delays retirement by one cycle. There is no starvation bound; the pipeline must bubble W eventually.
- rd=0 without exception: `multOngoing` drops the cycle after `md_ready`.
- Back-to-back: a new issue is accepted in the first IDLE cycle after retirement.

## Test plan
- Basic mult, rd=5: `mult $5,$1,$2`, `op_a`=6, `op_b`=7, `md_ready`+`md_result`=42 at t+4 → `md_start_mult` at t+1 only; `rf_we`=1, rd=5, data=42 at t+5; `multOngoing`=1 over t..t+5.
- Port conflict: as above, `wb_pipe_we`=1 (rd=3, data=9) at t+5 and t+6 → `rf_*` shows rd=3/9 on those cycles; rd=5/42 at t+7; IDLE at t+8.
- Div by zero: `div $8,$1,$2` with `md_exception`=1 at `md_ready` → `rf_rd`=30, `rf_data`=5; `$8` never written.
- Timeout: `mult`, no `md_ready` for TIMEOUT=64 BUSY cycles → WB_PEND; `rf_rd`=30, `rf_data`=4; IDLE next cycle.
- Edge cases:
  - rd=0: `mult $0` → no `rf_we` from the buffer.
  - Illegal issue: `is_md` while BUSY → `inM` unchanged.
  - Reset mid-op: `reset` in BUSY → no write; `multOngoing`=0 the next cycle.
- Non-md instruction: `add` with `issue_valid`=1 → no start pulse; `multOngoing`=0; `inM`=0.
